scrambler_data_sel: RTL
=======================

SCRAMBLER_DATA_SEL -- requirements
Module: scrambler_data_sel

Interface
REQ-001 SHALL have parameter CTRL_ADDR, default 12'h6d, the control register address.
REQ-002 SHALL have parameter LEN_ADDR, default 12'h6e, the frame-length register address.
REQ-003 SHALL have clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have write  input  1  register write strobe, shared with the primary LFSR bus.
REQ-006 SHALL have addr  input  12  register address.
REQ-007 SHALL have wdata  input  32  register write data.
REQ-008 SHALL have bits_stream  input  10  keystream from the primary LFSR; valid every cycle.
REQ-009 SHALL have lfsr_enable  output  1  LFSR advance request, one step per consumed byte.
REQ-010 SHALL have din  input  8  plaintext byte.
REQ-011 SHALL have din_valid  input  1  din qualifier.
REQ-012 SHALL have din_ready  output  1  byte accepted when din_valid & din_ready.
REQ-013 SHALL have dout  output  8  scrambled byte, registered.
REQ-014 SHALL have dout_valid  output  1  dout qualifier.
REQ-015 SHALL have dout_ready  input  1  downstream accepts when dout_valid & dout_ready.
REQ-016 SHALL have byte_cnt  output  16  bytes accepted in the current frame.
REQ-017 SHALL have frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-018 Registers: ctrl (bit0 run, bit1 bypass) written when write & addr==CTRL_ADDR; frame_len = wdata[15:0] written when write & addr==LEN_ADDR; other addresses ignored.
REQ-019 FSM states IDLE, RUN, DONE; IDLE->RUN on ctrl write with bit0=1; RUN->DONE on the accept that makes byte_cnt equal frame_len (frame_len != 0); DONE->RUN on ctrl write with bit0=1; any state->IDLE on ctrl write with bit0=0.
REQ-020 frame_len==0 means unlimited frame; RUN never exits to DONE by count.
REQ-021 byte_cnt cleared on every transition into RUN; incremented by 1 per accept; wraps 16'hFFFF->0 when frame_len==0.
REQ-022 din_ready = (state==RUN) & (~dout_valid | dout_ready); single-entry output stage, full throughput, 1-cycle latency din->dout.
REQ-023 Key select by bits_stream[9:8]: 00 key=bits[7:0]; 01 key=bit-reversed bits[7:0]; 10 key=~bits[7:0]; 11 key=bits[7:0] rotated left by 1.
REQ-024 dout loaded with din ^ key on accept; key forced to 8'h00 when ctrl bit1 (bypass) is set.
REQ-025 lfsr_enable = din_valid & din_ready & ~bypass & ~lfsr_wr, where lfsr_wr = write & addr in {12'h6a, 12'h6b, 12'h6c}; a byte accepted during lfsr_wr uses the current key and does not advance the LFSR.
REQ-026 dout_valid set on accept; cleared on dout_ready when no new accept in the same cycle; dout and dout_valid held while dout_valid & ~dout_ready.
REQ-027 frame_done asserted for exactly one cycle, the cycle after the RUN->DONE accept.
REQ-028 Leaving RUN (to IDLE or DONE) SHALL NOT discard a pending output byte; it drains normally.
REQ-029 Ctrl write and accept in the same cycle: the accept completes under the old state, then the state transition applies.

Reset
REQ-030 On rst: state IDLE, ctrl 0, frame_len 0, dout 8'h00, dout_valid 0, byte_cnt 0, frame_done 0; din_ready and lfsr_enable are 0 while rst is high.
REQ-031 Reset mid-frame SHALL drop any pending output byte and return to IDLE within one cycle.

Verification
REQ-032 Run, mode 00: bits_stream=10'h0A5, din=8'h3C accepted -> next cycle dout=8'h99, dout_valid=1, lfsr_enable was 1 on the accept cycle.
REQ-033 Modes 01/10/11: bits 10'h101, din 8'h00 -> dout 8'h80; bits 10'h2FF, din 8'h5A -> dout 8'h5A; bits 10'h381, din 8'h00 -> dout 8'h03.
REQ-034 frame_len=3, 3 back-to-back bytes, dout_ready=1 -> byte_cnt 1,2,3; frame_done pulses once; din_ready=0 in DONE; ctrl write 1 -> byte_cnt=0, RUN.
REQ-035 Backpressure: dout_ready=0 with dout_valid=1 -> din_ready=0, dout stable, lfsr_enable=0; release -> next byte accepted in the same cycle.
REQ-036 Bypass=1, din=8'hC3 -> dout=8'hC3, lfsr_enable=0; write to 12'h6b coincident with accept -> lfsr_enable=0.
REQ-037 rst asserted with dout_valid=1 in RUN -> next cycle dout_valid=0, dout=8'h00, state IDLE, byte_cnt=0.

Source files
------------

// File: rtl/scrambler_data_sel.sv
// Byte scrambler: XORs plaintext with an LFSR-derived key chosen by bits_stream[9:8],
// framed by a small register-controlled IDLE/RUN/DONE state machine.
module scrambler_data_sel #(
  parameter logic [11:0] CTRL_ADDR = 12'h06d,
  parameter logic [11:0] LEN_ADDR  = 12'h06e
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  input  logic [9:0]  bits_stream,
  output logic        lfsr_enable,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [7:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [15:0] byte_cnt,
  output logic        frame_done
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         ctrl;
  logic [CNT_W-1:0]   frame_len;
  logic               ctrl_wr, len_wr, lfsr_wr;
  logic               accept, last_byte, bypass;
  logic               cnt_clr, done_pulse;
  logic [7:0]         key;
  logic [7:0]         raw;

  assign ctrl_wr   = write & (addr == CTRL_ADDR);
  assign len_wr    = write & (addr == LEN_ADDR);
  assign lfsr_wr   = write & ((addr == 12'h06a) | (addr == 12'h06b) | (addr == 12'h06c));
  assign bypass    = ctrl[1];

  assign din_ready   = ~rst & (state == RUN) & (~dout_valid | dout_ready);
  assign accept      = din_valid & din_ready;
  assign lfsr_enable = accept & ~bypass & ~lfsr_wr;
  assign last_byte   = (frame_len != '0) & ((byte_cnt + CNT_W'(1)) == frame_len);
  assign raw         = bits_stream[7:0];

  // Key mode select; bypass zeroes the key so data passes through unchanged
  always_comb begin
    key = raw;
    case (bits_stream[9:8])
      2'b00:   key = raw;
      2'b01:   for (int i = 0; i < 8; i++) key[i] = raw[7-i];
      2'b10:   key = ~raw;
      default: key = {raw[6:0], raw[7]};
    endcase
    if (bypass) key = 8'h00;
  end

  // Accept-driven transition resolves first, then a coincident ctrl write overrides it
  always_comb begin
    state_nxt  = state;
    cnt_clr    = 1'b0;
    done_pulse = 1'b0;
    if (accept && last_byte) begin
      state_nxt  = DONE;
      done_pulse = 1'b1;
    end
    if (ctrl_wr) begin
      if (!wdata[0]) begin
        state_nxt = IDLE;
      end else if (state_nxt != RUN) begin
        state_nxt = RUN;
        cnt_clr   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl       <= 2'b00;
      frame_len  <= '0;
      dout       <= 8'h00;
      dout_valid <= 1'b0;
      byte_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl      <= wdata[1:0];
      if (len_wr)  frame_len <= wdata[CNT_W-1:0];
      frame_done <= done_pulse;
      if (cnt_clr)     byte_cnt <= '0;
      else if (accept) byte_cnt <= byte_cnt + CNT_W'(1);
      // Single-entry output stage: a pending byte drains regardless of state
      if (accept) begin
        dout       <= din ^ key;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
